// File: rtl/branch_sequencer.sv
// Decode-stage branch controller: sizes operand-hazard stalls, selects MEM->ID
// forwarding for the comparator, redirects the PC on taken branches, counts statistics.
module branch_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             BranchD,
    input  logic             UsesRtD,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic             ConditionD,
    input  logic [4:0]       WriteRegE,
    input  logic             RegWriteE,
    input  logic             MemtoRegE,
    input  logic [4:0]       WriteRegM,
    input  logic             RegWriteM,
    input  logic             MemtoRegM,
    input  logic             StallExt,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushE,
    output logic             FlushD,
    output logic             PCSrcD,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic [CNT_W-1:0] BranchCnt,
    output logic [CNT_W-1:0] TakenCnt,
    output logic [CNT_W-1:0] StallCnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [1:0]       r_cnt;
    logic [1:0]       w_nextCnt;
    logic [CNT_W-1:0] r_branchCnt;
    logic [CNT_W-1:0] r_takenCnt;
    logic [CNT_W-1:0] r_stallCnt;

    logic       w_srcA;
    logic       w_srcB;
    logic       w_hitEA;
    logic       w_hitEB;
    logic       w_hitMA;
    logic       w_hitMB;
    logic [1:0] w_needA;
    logic [1:0] w_needB;
    logic [1:0] w_need;
    logic       w_resolve;
    logic       w_hazStall;

    assign w_srcA  = (RsD != 5'd0);
    assign w_srcB  = UsesRtD && (RtD != 5'd0);
    assign w_hitEA = w_srcA && (RsD == WriteRegE) && RegWriteE;
    assign w_hitEB = w_srcB && (RtD == WriteRegE) && RegWriteE;
    assign w_hitMA = w_srcA && (RsD == WriteRegM) && RegWriteM;
    assign w_hitMB = w_srcB && (RtD == WriteRegM) && RegWriteM;

    // A load in EX needs two cycles before its data reaches WB; an ALU result in EX
    // or a load in MEM needs one. WB producers are covered by the split-cycle regfile.
    always_comb begin
        w_needA = 2'd0;
        if (w_hitEA && MemtoRegE)
            w_needA = 2'd2;
        else if (w_hitEA || (w_hitMA && MemtoRegM))
            w_needA = 2'd1;
    end

    always_comb begin
        w_needB = 2'd0;
        if (w_hitEB && MemtoRegE)
            w_needB = 2'd2;
        else if (w_hitEB || (w_hitMB && MemtoRegM))
            w_needB = 2'd1;
    end

    assign w_need = (w_needA > w_needB) ? w_needA : w_needB;

    assign ForwardAD = w_hitMA && !MemtoRegM;
    assign ForwardBD = w_hitMB && !MemtoRegM;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        FlushE      = 1'b0;
        FlushD      = 1'b0;
        PCSrcD      = 1'b0;
        w_resolve   = 1'b0;
        w_hazStall  = 1'b0;
        if (StallExt) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (BranchD) begin
                        if (w_need != 2'd0) begin
                            StallF     = 1'b1;
                            StallD     = 1'b1;
                            FlushE     = 1'b1;
                            w_hazStall = 1'b1;
                            if (w_need == 2'd2) begin
                                w_nextState = STALL;
                                w_nextCnt   = 2'd1;
                            end
                        end else begin
                            PCSrcD    = ConditionD;
                            FlushD    = ConditionD;
                            w_resolve = 1'b1;
                        end
                    end
                end
                STALL: begin
                    StallF     = 1'b1;
                    StallD     = 1'b1;
                    FlushE     = 1'b1;
                    w_hazStall = 1'b1;
                    w_nextCnt  = r_cnt - 2'd1;
                    if (r_cnt == 2'd1)
                        w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextCnt   = 2'd0;
                end
            endcase
        end
    end

    // Under StallExt the combinational block already holds state and raises no
    // resolve/hazard strobe, so every register simply freezes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 2'd0;
            r_branchCnt <= '0;
            r_takenCnt  <= '0;
            r_stallCnt  <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_resolve)
                r_branchCnt <= r_branchCnt + 1'b1;
            if (w_resolve && ConditionD)
                r_takenCnt <= r_takenCnt + 1'b1;
            if (w_hazStall)
                r_stallCnt <= r_stallCnt + 1'b1;
        end
    end

    assign BranchCnt = r_branchCnt;
    assign TakenCnt  = r_takenCnt;
    assign StallCnt  = r_stallCnt;

endmodule

// File: tb/tb_branch_sequencer.sv
// Directed bench for branch_sequencer: hand-computed control vectors and counter
// values over hazard, forwarding, freeze, reset and wrap scenarios.
module tb_branch_sequencer;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             BranchD;
    logic             UsesRtD;
    logic [4:0]       RsD;
    logic [4:0]       RtD;
    logic             ConditionD;
    logic [4:0]       WriteRegE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic [4:0]       WriteRegM;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic             StallExt;
    logic             StallF;
    logic             StallD;
    logic             FlushE;
    logic             FlushD;
    logic             PCSrcD;
    logic             ForwardAD;
    logic             ForwardBD;
    logic [CNT_W-1:0] BranchCnt;
    logic [CNT_W-1:0] TakenCnt;
    logic [CNT_W-1:0] StallCnt;

    int totalChecks = 0;
    int badChecks   = 0;

    branch_sequencer #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .BranchD(BranchD), .UsesRtD(UsesRtD),
        .RsD(RsD), .RtD(RtD), .ConditionD(ConditionD),
        .WriteRegE(WriteRegE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
        .StallExt(StallExt), .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .FlushD(FlushD), .PCSrcD(PCSrcD), .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .BranchCnt(BranchCnt), .TakenCnt(TakenCnt), .StallCnt(StallCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Control vector order: {StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD}
    function automatic logic [6:0] ctrlVec();
        return {StallF, StallD, FlushE, FlushD, PCSrcD, ForwardAD, ForwardBD};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic br, input logic usesRt, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic cond,
                                 input logic [4:0] wrE, input logic rwE, input logic m2rE,
                                 input logic [4:0] wrM, input logic rwM, input logic m2rM,
                                 input logic ext);
        BranchD    = br;
        UsesRtD    = usesRt;
        RsD        = rs;
        RtD        = rt;
        ConditionD = cond;
        WriteRegE  = wrE;
        RegWriteE  = rwE;
        MemtoRegE  = m2rE;
        WriteRegM  = wrM;
        RegWriteM  = rwM;
        MemtoRegM  = m2rM;
        StallExt   = ext;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCounters(input string tag, input int br, input int tk, input int st);
        checkOutput({tag, "_branchCnt"}, 32'(BranchCnt), 32'(br));
        checkOutput({tag, "_takenCnt"},  32'(TakenCnt),  32'(tk));
        checkOutput({tag, "_stallCnt"},  32'(StallCnt),  32'(st));
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("reset_ctrl", 32'(ctrlVec()), 32'h00);
        checkCounters("reset", 0, 0, 0);

        // No hazard, taken beq
        applyStimulus(1, 1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("nohaz_ctrl", 32'(ctrlVec()), 32'b0001100);
        tick();
        checkCounters("nohaz", 1, 1, 0);
        applyStimulus(0, 0, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("idle_ctrl", 32'(ctrlVec()), 32'h00);

        // ALU producer in EX on Rs: one stall, then forward A and resolve
        applyStimulus(1, 1, 3, 4, 0, 3, 1, 0, 0, 0, 0, 0);
        checkOutput("aluE_stall", 32'(ctrlVec()), 32'b1110000);
        tick();
        checkCounters("aluE_s", 1, 1, 1);
        applyStimulus(1, 1, 3, 4, 1, 0, 0, 0, 3, 1, 0, 0);
        checkOutput("aluE_resolve", 32'(ctrlVec()), 32'b0001110);
        tick();
        checkCounters("aluE", 2, 2, 1);

        // Load in EX on Rt: two stalls via STALL, then not-taken
        applyStimulus(1, 1, 5, 6, 0, 6, 1, 1, 0, 0, 0, 0);
        checkOutput("ldE_stall1", 32'(ctrlVec()), 32'b1110000);
        tick();
        applyStimulus(1, 1, 5, 6, 0, 0, 0, 0, 6, 1, 1, 0);
        checkOutput("ldE_stall2", 32'(ctrlVec()), 32'b1110000);
        tick();
        applyStimulus(1, 1, 5, 6, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ldE_resolve", 32'(ctrlVec()), 32'h00);
        tick();
        checkCounters("ldE", 3, 2, 3);

        // Load in MEM on Rs: one stall
        applyStimulus(1, 1, 7, 4, 1, 0, 0, 0, 7, 1, 1, 0);
        checkOutput("ldM_stall", 32'(ctrlVec()), 32'b1110000);
        tick();
        applyStimulus(1, 1, 7, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ldM_resolve", 32'(ctrlVec()), 32'b0001100);
        tick();
        checkCounters("ldM", 4, 3, 4);

        // bgtz ignores Rt match; $0 source/destination never stalls
        applyStimulus(1, 0, 8, 9, 1, 9, 1, 1, 0, 0, 0, 0);
        checkOutput("bgtz_norT", 32'(ctrlVec()), 32'b0001100);
        tick();
        applyStimulus(1, 1, 0, 10, 0, 0, 1, 1, 0, 0, 0, 0);
        checkOutput("zero_dest", 32'(ctrlVec()), 32'h00);
        tick();
        checkCounters("bgtz_zero", 6, 4, 4);

        // ALU in MEM on Rt: forward B, no stall
        applyStimulus(1, 1, 11, 12, 0, 0, 0, 0, 12, 1, 0, 0);
        checkOutput("fwdB", 32'(ctrlVec()), 32'b0000001);
        tick();
        checkCounters("fwdB", 7, 4, 4);

        // StallExt freezes STALL for 3 cycles: 5 stall cycles total, 2 counted
        applyStimulus(1, 1, 13, 14, 1, 13, 1, 1, 0, 0, 0, 0);
        checkOutput("ext_stall1", 32'(ctrlVec()), 32'b1110000);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 1, 13, 14, 1, 0, 0, 0, 13, 1, 1, 1);
            checkOutput("ext_frozen", 32'(ctrlVec()), 32'b1100000);
            tick();
            checkOutput("ext_stallCnt", 32'(StallCnt), 32'd5);
        end
        applyStimulus(1, 1, 13, 14, 1, 0, 0, 0, 13, 1, 1, 0);
        checkOutput("ext_stall2", 32'(ctrlVec()), 32'b1110000);
        tick();
        applyStimulus(1, 1, 13, 14, 1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("ext_resolve", 32'(ctrlVec()), 32'b0001100);
        tick();
        checkCounters("ext", 8, 5, 6);

        // StallExt on a resolve cycle suppresses redirect and counting
        applyStimulus(1, 1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("ext_idle", 32'(ctrlVec()), 32'b1100000);
        tick();
        checkCounters("ext_idle", 8, 5, 6);

        // Reset while in STALL returns to IDLE and clears counters
        applyStimulus(1, 1, 15, 4, 0, 15, 1, 1, 0, 0, 0, 0);
        tick();
        checkOutput("rst_pre_stallCnt", 32'(StallCnt), 32'd7);
        rst = 1'b1;
        applyStimulus(1, 1, 15, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_in_stall", 32'(ctrlVec()), 32'b1110000);
        tick();
        checkCounters("rst", 0, 0, 0);
        rst = 1'b0;
        applyStimulus(1, 1, 15, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_idle", 32'(ctrlVec()), 32'h00);
        tick();
        checkCounters("rst_after", 1, 0, 0);

        // Wrap: 2^CNT_W resolves bring BranchCnt back to 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        applyStimulus(1, 1, 3, 4, 1, 0, 0, 0, 0, 0, 0, 0);
        repeat ((1 << CNT_W) - 1) tick();
        checkOutput("wrap_max", 32'(BranchCnt), 32'((1 << CNT_W) - 1));
        tick();
        checkOutput("wrap_branch", 32'(BranchCnt), 32'd0);
        checkOutput("wrap_taken", 32'(TakenCnt), 32'd0);

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
